// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
// Shared definitions for the stepper pulse driver:
//   - state_t      : move sequencer states
//   - DEFAULT_*    : default timing constants in clk cycles
//   - max3()       : helper used to size the shared step timer
// Optional feature macro used by the driver: STEPPER_POS_TRACK_EN
// -----------------------------------------------------------------------------
package stepper_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DIR_SETUP  = 3'd1,
    PULSE_HIGH = 3'd2,
    PULSE_LOW  = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam int DEFAULT_PULSE_HIGH_CYCLES   = 50;
  localparam int DEFAULT_PULSE_PERIOD_CYCLES = 200;
  localparam int DEFAULT_DIR_SETUP_CYCLES    = 20;

  // Largest of three timing values; the timer must hold the biggest load.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Loadable down-counter shared by every timed state of the pulse driver.
// Loading N makes expire assert on the N-th cycle after the load edge, so a
// state that loads N on entry and leaves on expire lasts exactly N cycles.
// The counter parks at zero and never wraps.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : load value into the counter this edge
//   value      : cycle count to load
//   expire     : high while the counter holds its terminal count of 1
// -----------------------------------------------------------------------------
module step_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/stepper_pulse_driver.sv
// -----------------------------------------------------------------------------
// stepper_pulse_driver
// Consumer end of the controller->stepper handshake. On a rising edge of
// data_ready while idle, latches step counts and directions for both SCARA
// joints, waits for DIR setup, then emits lock-step STEP pulse trains until
// both counts are exhausted, pulses move_done and returns to idle.
// Optional feature: define STEPPER_POS_TRACK_EN to add signed 16-bit position
// accumulators pos1/pos2 updated by every emitted STEP pulse.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   steps1, steps2    : per-joint step counts (sampled at accept only)
//   dir1, dir2        : per-joint directions (sampled at accept only)
//   data_ready        : command strobe, only its rising edge is used
//   step1_out/2_out   : STEP outputs to the drivers
//   dir1_out/2_out    : DIR outputs, held from accept until the next accept
//   stepper_ready     : high only while idle
//   move_done         : one-cycle pulse at move completion
//   pos1, pos2        : (STEPPER_POS_TRACK_EN only) position accumulators
// -----------------------------------------------------------------------------
module stepper_pulse_driver
  import stepper_pkg::*;
#(
  parameter int PULSE_HIGH_CYCLES   = DEFAULT_PULSE_HIGH_CYCLES,
  parameter int PULSE_PERIOD_CYCLES = DEFAULT_PULSE_PERIOD_CYCLES,
  parameter int DIR_SETUP_CYCLES    = DEFAULT_DIR_SETUP_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        steps1,
  input  logic [7:0]        steps2,
  input  logic              dir1,
  input  logic              dir2,
  input  logic              data_ready,
  output logic              step1_out,
  output logic              step2_out,
  output logic              dir1_out,
  output logic              dir2_out,
  output logic              stepper_ready,
  output logic              move_done
`ifdef STEPPER_POS_TRACK_EN
  ,
  output logic signed [15:0] pos1,
  output logic signed [15:0] pos2
`endif
);

  localparam int LOW_CYCLES = PULSE_PERIOD_CYCLES - PULSE_HIGH_CYCLES;
  localparam int TIMER_MAX  = max3(PULSE_HIGH_CYCLES, LOW_CYCLES, DIR_SETUP_CYCLES);
  localparam int TW         = $clog2(TIMER_MAX + 1);

  state_t          state;
  state_t          next_state;
  logic            data_ready_q;
  logic            accept;
  logic [7:0]      rem1;
  logic [7:0]      rem2;
  logic            active1;
  logic            active2;
  logic            timer_load;
  logic [TW-1:0]   timer_value;
  logic            timer_expire;
  logic            enter_high;
  logic            high_exit;

  step_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .value  (timer_value),
    .expire (timer_expire)
  );

  // Edge detector register starts high so a level held through reset is
  // not mistaken for a fresh command.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ready_q <= 1'b1;
    end else begin
      data_ready_q <= data_ready;
    end
  end

  assign accept = (state == IDLE) && data_ready && !data_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and timer reload. Every timed state loads its own duration on
  // the edge that enters it and leaves when the timer expires.
  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state  = DIR_SETUP;
          timer_load  = 1'b1;
          timer_value = TW'(DIR_SETUP_CYCLES);
        end
      end
      DIR_SETUP: begin
        if (timer_expire) begin
          if (rem1 == 8'd0 && rem2 == 8'd0) begin
            next_state = DONE;
          end else begin
            next_state  = PULSE_HIGH;
            timer_load  = 1'b1;
            timer_value = TW'(PULSE_HIGH_CYCLES);
          end
        end
      end
      PULSE_HIGH: begin
        if (timer_expire) begin
          next_state  = PULSE_LOW;
          timer_load  = 1'b1;
          timer_value = TW'(LOW_CYCLES);
        end
      end
      PULSE_LOW: begin
        if (timer_expire) begin
          if (rem1 == 8'd0 && rem2 == 8'd0) begin
            next_state = DONE;
          end else begin
            next_state  = PULSE_HIGH;
            timer_load  = 1'b1;
            timer_value = TW'(PULSE_HIGH_CYCLES);
          end
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign enter_high = (next_state == PULSE_HIGH) && (state != PULSE_HIGH);
  assign high_exit  = (state == PULSE_HIGH) && timer_expire;

  // Command latch, per-pulse active mask and remaining-step bookkeeping.
  // An axis whose count is exhausted drops out of the mask and stays quiet
  // while the other axis keeps pulsing.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem1     <= 8'd0;
      rem2     <= 8'd0;
      dir1_out <= 1'b0;
      dir2_out <= 1'b0;
      active1  <= 1'b0;
      active2  <= 1'b0;
    end else begin
      if (accept) begin
        rem1     <= steps1;
        rem2     <= steps2;
        dir1_out <= dir1;
        dir2_out <= dir2;
      end
      if (enter_high) begin
        active1 <= (rem1 != 8'd0);
        active2 <= (rem2 != 8'd0);
      end
      if (high_exit) begin
        if (active1 && rem1 != 8'd0) begin
          rem1 <= rem1 - 8'd1;
        end
        if (active2 && rem2 != 8'd0) begin
          rem2 <= rem2 - 8'd1;
        end
      end
    end
  end

  assign step1_out     = (state == PULSE_HIGH) && active1;
  assign step2_out     = (state == PULSE_HIGH) && active2;
  assign stepper_ready = (state == IDLE);
  assign move_done     = (state == DONE);

`ifdef STEPPER_POS_TRACK_EN
  // Each completed STEP pulse moves the joint one count in its DIR sense;
  // the accumulators wrap two's-complement.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos1 <= 16'sd0;
      pos2 <= 16'sd0;
    end else if (high_exit) begin
      if (active1) begin
        pos1 <= dir1_out ? pos1 + 16'sd1 : pos1 - 16'sd1;
      end
      if (active2) begin
        pos2 <= dir2_out ? pos2 + 16'sd1 : pos2 - 16'sd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stepper_pulse_driver.sv
// -----------------------------------------------------------------------------
// tb_stepper_pulse_driver
// Scoreboard bench for stepper_pulse_driver with default timing. Each issued
// command pushes its expected move summary; a monitor measures pulse counts,
// widths, periods, first-edge offset and ready-low duration and compares on
// every move_done. Position checks compile in with STEPPER_POS_TRACK_EN.
// -----------------------------------------------------------------------------
module tb_stepper_pulse_driver;

  localparam int HIGH   = 50;
  localparam int PERIOD = 200;
  localparam int SETUP  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] steps1 = 8'd0;
  logic [7:0] steps2 = 8'd0;
  logic       dir1 = 1'b0;
  logic       dir2 = 1'b0;
  logic       data_ready = 1'b1;
  logic       step1_out, step2_out, dir1_out, dir2_out, stepper_ready, move_done;
`ifdef STEPPER_POS_TRACK_EN
  logic signed [15:0] pos1, pos2;
`endif

  stepper_pulse_driver dut (
    .clk           (clk),
    .reset         (reset),
    .steps1        (steps1),
    .steps2        (steps2),
    .dir1          (dir1),
    .dir2          (dir2),
    .data_ready    (data_ready),
    .step1_out     (step1_out),
    .step2_out     (step2_out),
    .dir1_out      (dir1_out),
    .dir2_out      (dir2_out),
    .stepper_ready (stepper_ready),
    .move_done     (move_done)
`ifdef STEPPER_POS_TRACK_EN
    ,
    .pos1          (pos1),
    .pos2          (pos2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int   p1;
    int   p2;
    int   low;
    logic d1;
    logic d2;
  } move_t;

  move_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Monitor bookkeeping
  int   low_cnt = 0;
  int   c1 = 0, c2 = 0;
  int   first1 = 0, first2 = 0;
  int   last1 = -1, last2 = -1;
  int   hi1 = 0, hi2 = 0;
  int   bad = 0;
  logic prev_rdy = 1'b1, prev_s1 = 1'b0, prev_s2 = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Issue one command via a data_ready rising edge, then scramble inputs to
  // show they are only sampled at accept.
  task automatic applyStimulus(input int s1, input int s2, input logic d1,
                               input logic d2, input bit push);
    move_t e;
    @(negedge clk);
    steps1 = 8'(s1);
    steps2 = 8'(s2);
    dir1   = d1;
    dir2   = d2;
    if (push) begin
      e.p1  = s1;
      e.p2  = s2;
      e.low = SETUP + ((s1 > s2) ? s1 : s2) * PERIOD + 1;
      e.d1  = d1;
      e.d2  = d2;
      exp_q.push_back(e);
    end
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    data_ready = 1'b0;
    steps1 = 8'hA5;
    steps2 = 8'h5A;
    dir1   = ~d1;
    dir2   = ~d2;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (!stepper_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", int'(stepper_ready), 1);
  endtask

  // Monitor: measures each move and compares it to the scoreboard entry.
  always @(negedge clk) begin
    move_t e;
    if (reset) begin
      low_cnt = 0;
      c1 = 0;
      c2 = 0;
    end else begin
      if (prev_rdy && !stepper_ready) begin
        low_cnt = 0; c1 = 0; c2 = 0; first1 = 0; first2 = 0;
        last1 = -1; last2 = -1; hi1 = 0; hi2 = 0; bad = 0;
      end
      if (!stepper_ready) low_cnt++;
      if (step1_out) begin
        if (!prev_s1) begin
          c1++;
          if (first1 == 0) first1 = low_cnt;
          if (last1 >= 0 && low_cnt - last1 != PERIOD) bad++;
          last1 = low_cnt;
          hi1 = 0;
        end
        hi1++;
      end else if (prev_s1 && hi1 != HIGH) begin
        bad++;
      end
      if (step2_out) begin
        if (!prev_s2) begin
          c2++;
          if (first2 == 0) first2 = low_cnt;
          if (last2 >= 0 && low_cnt - last2 != PERIOD) bad++;
          last2 = low_cnt;
          hi2 = 0;
        end
        hi2++;
      end else if (prev_s2 && hi2 != HIGH) begin
        bad++;
      end
      if (move_done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_move_done", int'(move_done), 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pulses1", c1, e.p1);
          checkOutput("pulses2", c2, e.p2);
          checkOutput("ready_low_cycles", low_cnt, e.low);
          checkOutput("first_edge1", first1, (e.p1 > 0) ? SETUP + 1 : 0);
          checkOutput("first_edge2", first2, (e.p2 > 0) ? SETUP + 1 : 0);
          checkOutput("width_period_errors", bad, 0);
          checkOutput("dir1_out", int'(dir1_out), int'(e.d1));
          checkOutput("dir2_out", int'(dir2_out), int'(e.d2));
        end
      end
    end
    prev_rdy = stepper_ready;
    prev_s1  = step1_out;
    prev_s2  = step2_out;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int done_seen;
    // Reset with data_ready held high: no command may be accepted.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("reset_ready", int'(stepper_ready), 1);
    checkOutput("reset_step1", int'(step1_out), 0);
    checkOutput("reset_step2", int'(step2_out), 0);
    checkOutput("reset_dir1", int'(dir1_out), 0);
    checkOutput("reset_dir2", int'(dir2_out), 0);
    checkOutput("reset_move_done", int'(move_done), 0);
    data_ready = 1'b0;

    // Uneven two-axis move.
    applyStimulus(3, 5, 1'b1, 1'b0, 1'b1);
    waitIdle(1500);
    repeat (3) @(negedge clk);
    checkOutput("dir1_hold", int'(dir1_out), 1);

    // Zero move.
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
    waitIdle(100);

    // Rising edge during a move is ignored; next edge after idle accepted.
    applyStimulus(2, 0, 1'b1, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    steps1 = 8'd7;
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    data_ready = 1'b0;
    waitIdle(1000);
    applyStimulus(1, 1, 1'b0, 1'b1, 1'b1);
    waitIdle(500);

    // Reset in the middle of the third pulse of a 5-step move.
    applyStimulus(5, 5, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (c1 < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("third_pulse_seen", c1, 3);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_step1", int'(step1_out), 0);
    checkOutput("abort_step2", int'(step2_out), 0);
    checkOutput("abort_ready", int'(stepper_ready), 1);
    checkOutput("abort_dir1", int'(dir1_out), 0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (1200) begin
      @(negedge clk);
      if (move_done) done_seen++;
    end
    checkOutput("abort_no_move_done", done_seen, 0);

`ifdef STEPPER_POS_TRACK_EN
    checkOutput("pos1_reset", int'(pos1), 0);
    applyStimulus(5, 0, 1'b1, 1'b0, 1'b1);
    waitIdle(1500);
    checkOutput("pos1_plus5", int'(pos1), 5);
    applyStimulus(7, 0, 1'b0, 1'b0, 1'b1);
    waitIdle(2000);
    checkOutput("pos1_minus2", int'(pos1), -2);
    checkOutput("pos2_idle_axis", int'(pos2), 0);
`endif

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
